osd_ram_wr_sched: RTL

Write-port scheduler for the 2048x8 OSD character RAM. It shares the RAM's single write port between two requesters: a host byte-write channel (valid/ready) and a hardware fill engine that writes a constant value over an address range. It sits in the wr_clk domain directly in front of the OSD RAM write port and drives that port's wr_en, wr_addr and wr_data from registers.

---
 rtl/osd_ram_wr_sched.sv | 103 ++++++++++
 1 files changed

// File: rtl/osd_ram_wr_sched.sv
// Write-port scheduler for the OSD character RAM: round-robin between host
// byte writes and a constant-value fill engine, registered onto the RAM port.
module osd_ram_wr_sched #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [ADDR_WIDTH:0]   fill_len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data
);

    typedef enum logic [1:0] {F_IDLE, F_RUN, F_DONE} fstate_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    fstate_t               state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remain;
    logic [DATA_WIDTH-1:0] fill_val;
    logic                  last_fill;
    logic                  fill_req, host_gnt, fill_gnt;
    logic [ADDR_WIDTH:0]   len_clamped;

    assign fill_req    = (state == F_RUN);
    assign host_ready  = !fill_req | last_fill;
    assign host_gnt    = host_valid & host_ready;
    assign fill_gnt    = fill_req & !host_gnt;
    assign fill_busy   = (state != F_IDLE);
    assign fill_done   = (state == F_DONE);
    assign len_clamped = (fill_len > DEPTH) ? DEPTH : fill_len;

    always_comb begin
        state_nxt = state;
        case (state)
            F_IDLE:  if (fill_start) state_nxt = (fill_len == '0) ? F_DONE : F_RUN;
            F_RUN:   if (fill_gnt && remain == ONE) state_nxt = F_DONE;
            F_DONE:  state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state    <= F_IDLE;
            cur_addr <= '0;
            remain   <= '0;
            fill_val <= '0;
        end else begin
            state <= state_nxt;
            if (state == F_IDLE && fill_start) begin
                cur_addr <= fill_addr;
                remain   <= len_clamped;
                fill_val <= fill_value;
            end else if (fill_gnt) begin
                // address wraps naturally at the RAM depth
                cur_addr <= cur_addr + ADDR_WIDTH'(1);
                remain   <= remain - ONE;
            end
        end
    end

    // last_fill resets to 1 so the host wins the first contention
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            last_fill <= 1'b1;
        end else if (fill_gnt) begin
            last_fill <= 1'b1;
        end else if (host_gnt) begin
            last_fill <= 1'b0;
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else begin
            ram_wr_en <= host_gnt | fill_gnt;
            if (host_gnt) begin
                ram_wr_addr <= host_addr;
                ram_wr_data <= host_data;
            end else if (fill_gnt) begin
                ram_wr_addr <= cur_addr;
                ram_wr_data <= fill_val;
            end
        end
    end

endmodule
